zcash_host_msg_rx: RTL
======================

# zcash_host_msg_rx

Framing checker directly downstream of the AWS wrapper's 8-byte host-to-core stream (the `tx_zcash_if` output of the wrapper). Parses the 64-bit header of each host message, forwards well-formed messages to the Zcash core through a one-entry pipeline register, and repairs or drops malformed ones. Optional saturating statistics counters are exposed for the AXI-lite status block.

## Interface
- `MAX_LEN`, 16384: largest legal message length in bytes, header included.
- `CTL_BITS`, 8: width of `ctl`, passed through unchanged.
- `i_clk` in 1: single clock for all logic.
- `i_rst` in 1: synchronous, active-high reset.
- `rx_if` if_axi_stream.sink (DAT_BYTS=8): host stream. Carries `dat[63:0]`, `val`, `rdy`, `sop`, `eop`, `mod[2:0]`, `err`, `ctl`.
- `tx_if` if_axi_stream.source (DAT_BYTS=8): stream to the core. Same signal set as `rx_if`.
- `o_pkt_cnt` out 32: messages forwarded.
- `o_drop_cnt` out 32: messages dropped.
- `o_err_cnt` out 32: messages forwarded with `err`=1.

## Operation
- Header word (first word of a message): `len` = `dat[31:0]` (total bytes, header included); `cmd` = `dat[63:32]`.
- The block forwards the header itself.
- `mod` convention: 0 means all 8 bytes are valid; otherwise `mod` gives the number of valid bytes in the final word.
- State machine states: HDR, PAYLOAD, DISCARD.
- **HDR**
  - If `len` < 8 or `len` > `MAX_LEN`: drop the word, increment drop count.
    - If `eop`=1, stay in HDR; otherwise go to DISCARD.
  - Otherwise forward the word and load `rem` = `len` − 8 (32-bit).
    - If `rem` = 0, the output `eop` is forced to 1 and `mod` = `len[2:0]`.
    - If `rem` = 0 and the input `eop` = 0, the message is truncated: go to DISCARD.
    - If `rem` ≠ 0 and the input `eop` = 1, the message is short: output `err` = 1 and stay in HDR.
    - Else go to PAYLOAD.
- **PAYLOAD**: forward each word and decrement `rem` by min(`rem`, 8). The word that brings `rem` to 0 is the last word:
  - output `eop`=1 and `mod`=`len[2:0]`;
  - if the input `eop`=0, go to DISCARD (truncation, no `err`);
  - if the input `eop`=1 and the input `mod` ≠ `len[2:0]`, output `err`=1;
  - return to HDR.
  - If the input `eop`=1 while `rem` > 8: output `eop`=1, `err`=1, `mod` as input; go to HDR.
- **DISCARD**: `rx_if.rdy`=1. Accept and drop words until `eop`, then go to HDR. Nothing is emitted.
- Output `err` = input `err` OR any error detected above.
- `sop` on the output is 1 exactly on the forwarded header word.
- Counters (when compiled in):
  - `pkt_cnt` increments on every output `eop` handshake.
  - `err_cnt` increments on output `eop`&`err`.
  - `drop_cnt` increments on an HDR drop.
  - All three saturate at 32'hFFFF_FFFF.

## Timing
- Latency is one cycle from the input handshake to `tx_if.val`. Output is a single register stage.
- `rx_if.rdy` = `~tx_if.val | tx_if.rdy` in HDR/PAYLOAD; 1 in DISCARD. No combinational path from `rx_if.val` to `rx_if.rdy`.
- Output register holds its value while `tx_if.val`=1 and `tx_if.rdy`=0.
- Full throughput: one word per cycle when `tx_if.rdy` is held at 1.
- Reset values:
  - state = HDR, `rem` = 0;
  - `tx_if.val`=0, `sop`=0, `eop`=0, `err`=0, `mod`=0, `dat`=0, `ctl`=0;
  - all counters = 0.
- Reset mid-message: the partial message is abandoned and no `eop` is emitted. The next accepted word is treated as a header.
- Simultaneous events in the same cycle:
  - output handshake and input accept: the register reloads;
  - counter increment and saturation: saturation wins.

## Configuration
- `ZCASH_MSG_STATS_EN` defined: the three counters are implemented as above.
- Not defined: `o_pkt_cnt`, `o_drop_cnt` and `o_err_cnt` are tied to 0 and no counter flops exist. Framing behaviour is identical in both builds.

## Test plan
- 3-word message, `len`=20, input `eop` on word 3 with `mod`=4, `tx_if.rdy`=1 → 3 words out; `eop`/`mod`=4 on word 3, `err`=0; `pkt_cnt`=1; one-cycle latency.
- Header with `len`=4 followed by 2 more words, `eop` on word 3 → no output; `drop_cnt`=1; next message forwarded normally.
- `len`=16, 4 input words → 2 words out with `eop`/`mod`=0 on word 2; words 3–4 discarded with `rdy`=1; `err`=0.
- `len`=40, input `eop` on word 2 → output word 2 has `eop`=1, `err`=1; `err_cnt`=1.
- Random `tx_if.rdy` (50%) over 100 messages of `len` 8..`MAX_LEN` → output byte-exact, no loss or duplication, `rx_if.rdy` never 1 while the register is full and stalled.
- `i_rst` asserted during word 2 of a 5-word message, then a valid `len`=8 header with `eop` → no `eop` for the aborted message; single-word output with `sop`=`eop`=1.

Source files
------------

// File: rtl/zcash_host_msg_rx.sv
// zcash_host_msg_rx
// Framing checker between the AWS wrapper's 8-byte host-to-core stream and
// the Zcash core. Each message starts with a 64-bit header whose low 32 bits
// give the total length in bytes, header included, and whose high 32 bits
// give the command. Well-formed messages pass through a one-entry output
// register. Headers with an illegal length are dropped together with the
// rest of their message. Messages that are too long are cut at the declared
// length. Messages that end early are closed with err=1.
//
// Build option: define ZCASH_MSG_STATS_EN to add the saturating
// pkt/drop/err counters. Without it the counter outputs are tied to 0.
//
// Ports
//   i_clk, i_rst          : clock and synchronous active-high reset
//   rx_*                  : host stream sink (dat/val/rdy/sop/eop/mod/err/ctl)
//   tx_*                  : core stream source (same signal set)
//   o_pkt_cnt             : messages forwarded (output eop handshakes)
//   o_drop_cnt            : messages dropped at the header
//   o_err_cnt             : messages forwarded with err=1
module zcash_host_msg_rx #(
   parameter int MAX_LEN  = 16384,
   parameter int CTL_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [63:0]         rx_dat,
   input  logic                rx_val,
   output logic                rx_rdy,
   input  logic                rx_sop,
   input  logic                rx_eop,
   input  logic [2:0]          rx_mod,
   input  logic                rx_err,
   input  logic [CTL_BITS-1:0] rx_ctl,
   output logic [63:0]         tx_dat,
   output logic                tx_val,
   input  logic                tx_rdy,
   output logic                tx_sop,
   output logic                tx_eop,
   output logic [2:0]          tx_mod,
   output logic                tx_err,
   output logic [CTL_BITS-1:0] tx_ctl,
   output logic [31:0]         o_pkt_cnt,
   output logic [31:0]         o_drop_cnt,
   output logic [31:0]         o_err_cnt
);

   typedef enum logic [1:0] {HDR, PAYLOAD, DISCARD} state_t;

   state_t      state, next_state;
   logic [31:0] rem, next_rem;
   logic [2:0]  len_mod, next_len_mod;
   logic        accept;
   logic [31:0] hdr_len;
   logic        hdr_bad;
   logic        fwd;
   logic        fwd_sop;
   logic        fwd_eop;
   logic        fwd_err;
   logic [2:0]  fwd_mod;
   logic        drop;

   // Framing ignores the input sop. Any word accepted in HDR is a header.
   logic        unused_sop;
   assign unused_sop = rx_sop;

   assign hdr_len = rx_dat[31:0];
   assign hdr_bad = (hdr_len < 32'd8) || (hdr_len > 32'(MAX_LEN));

   // Ready depends only on the state and the output register, never on rx_val.
   // DISCARD swallows words even while the output register is stalled.
   assign rx_rdy = (state == DISCARD) | ~tx_val | tx_rdy;
   assign accept = rx_val & rx_rdy;

   // State register. It holds the parse state, the bytes still owed after
   // the current word, and the length residue that the last word must carry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= HDR;
         rem     <= '0;
         len_mod <= '0;
      end else begin
         state   <= next_state;
         rem     <= next_rem;
         len_mod <= next_len_mod;
      end
   end

   // Next-state logic. A message that ends before its declared length goes
   // back to HDR. A message that runs past its declared length enters
   // DISCARD until its input eop arrives.
   always_comb begin
      next_state   = state;
      next_rem     = rem;
      next_len_mod = len_mod;
      if (accept) begin
         case (state)
            HDR: begin
               if (hdr_bad) begin
                  next_state = rx_eop ? HDR : DISCARD;
               end else begin
                  next_rem     = hdr_len - 32'd8;
                  next_len_mod = hdr_len[2:0];
                  if (hdr_len == 32'd8) begin
                     next_state = rx_eop ? HDR : DISCARD;
                  end else if (rx_eop) begin
                     next_rem   = '0;
                     next_state = HDR;
                  end else begin
                     next_state = PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (rem <= 32'd8) begin
                  next_rem   = '0;
                  next_state = rx_eop ? HDR : DISCARD;
               end else if (rx_eop) begin
                  next_rem   = '0;
                  next_state = HDR;
               end else begin
                  next_rem = rem - 32'd8;
               end
            end
            DISCARD: begin
               if (rx_eop) next_state = HDR;
            end
            default: next_state = HDR;
         endcase
      end
   end

   // Output decode for the accepted word. This block decides whether the
   // word is forwarded or dropped, and how sop/eop/mod/err are rewritten.
   always_comb begin
      fwd     = 1'b0;
      drop    = 1'b0;
      fwd_sop = 1'b0;
      fwd_eop = rx_eop;
      fwd_mod = rx_mod;
      fwd_err = rx_err;
      if (accept) begin
         case (state)
            HDR: begin
               if (hdr_bad) begin
                  drop = 1'b1;
               end else begin
                  fwd     = 1'b1;
                  fwd_sop = 1'b1;
                  if (hdr_len == 32'd8) begin
                     fwd_eop = 1'b1;
                     fwd_mod = hdr_len[2:0];
                  end else if (rx_eop) begin
                     fwd_err = 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               fwd = 1'b1;
               if (rem <= 32'd8) begin
                  fwd_eop = 1'b1;
                  fwd_mod = len_mod;
                  if (rx_eop && (rx_mod != len_mod)) fwd_err = 1'b1;
               end else if (rx_eop) begin
                  fwd_err = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Single output register stage. A new word can only be loaded when the
   // register is empty or is being drained in the same cycle, so a reload
   // on a handshake cycle never loses data.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_val <= 1'b0;
         tx_sop <= 1'b0;
         tx_eop <= 1'b0;
         tx_err <= 1'b0;
         tx_mod <= '0;
         tx_dat <= '0;
         tx_ctl <= '0;
      end else if (fwd) begin
         tx_val <= 1'b1;
         tx_sop <= fwd_sop;
         tx_eop <= fwd_eop;
         tx_err <= fwd_err;
         tx_mod <= fwd_mod;
         tx_dat <= rx_dat;
         tx_ctl <= rx_ctl;
      end else if (tx_rdy) begin
         tx_val <= 1'b0;
      end
   end

`ifdef ZCASH_MSG_STATS_EN
   logic out_eop_hs;
   assign out_eop_hs = tx_val & tx_rdy & tx_eop;

   // Saturating statistics counters. Once a counter reaches all-ones it
   // stops incrementing and holds that value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pkt_cnt  <= '0;
         o_drop_cnt <= '0;
         o_err_cnt  <= '0;
      end else begin
         if (out_eop_hs && (o_pkt_cnt != 32'hFFFF_FFFF))
            o_pkt_cnt <= o_pkt_cnt + 32'd1;
         if (out_eop_hs && tx_err && (o_err_cnt != 32'hFFFF_FFFF))
            o_err_cnt <= o_err_cnt + 32'd1;
         if (drop && (o_drop_cnt != 32'hFFFF_FFFF))
            o_drop_cnt <= o_drop_cnt + 32'd1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
   assign o_pkt_cnt   = '0;
   assign o_drop_cnt  = '0;
   assign o_err_cnt   = '0;
`endif

endmodule
